// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU control and iterative multiply/divide unit.
package alu_pkg;

    localparam int unsigned ALU_CTRL_W = 4;
    localparam int unsigned FUNCT_W    = 6;

    typedef enum logic [2:0] {
        ALUOP_ADD   = 3'b000,
        ALUOP_SUB   = 3'b001,
        ALUOP_RTYPE = 3'b010,
        ALUOP_OR    = 3'b011,
        ALUOP_AND   = 3'b100,
        ALUOP_XOR   = 3'b101
    } aluop_e;

    // R-type function codes
    localparam logic [FUNCT_W-1:0] F_SLL   = 6'b000000;
    localparam logic [FUNCT_W-1:0] F_SRL   = 6'b000010;
    localparam logic [FUNCT_W-1:0] F_SRA   = 6'b000011;
    localparam logic [FUNCT_W-1:0] F_JR    = 6'b001000;
    localparam logic [FUNCT_W-1:0] F_MFHI  = 6'b010000;
    localparam logic [FUNCT_W-1:0] F_MTHI  = 6'b010001;
    localparam logic [FUNCT_W-1:0] F_MFLO  = 6'b010010;
    localparam logic [FUNCT_W-1:0] F_MTLO  = 6'b010011;
    localparam logic [FUNCT_W-1:0] F_MULT  = 6'b011000;
    localparam logic [FUNCT_W-1:0] F_MULTU = 6'b011001;
    localparam logic [FUNCT_W-1:0] F_DIV   = 6'b011010;
    localparam logic [FUNCT_W-1:0] F_DIVU  = 6'b011011;
    localparam logic [FUNCT_W-1:0] F_ADD   = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_SUB   = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_AND   = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR    = 6'b100101;
    localparam logic [FUNCT_W-1:0] F_XOR   = 6'b100110;
    localparam logic [FUNCT_W-1:0] F_NOR   = 6'b100111;
    localparam logic [FUNCT_W-1:0] F_SLT   = 6'b101010;
    localparam logic [FUNCT_W-1:0] F_SLTU  = 6'b101011;

    // ALU operation encodings
    localparam logic [ALU_CTRL_W-1:0] ALU_AND     = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR      = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD     = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR     = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR     = 4'b0100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU    = 4'b0101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB     = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT     = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL     = 4'b1000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL     = 4'b1001;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA     = 4'b1010;
    localparam logic [ALU_CTRL_W-1:0] ALU_ILLEGAL = 4'b1111;

    // MD op select is funct[1:0]: bit1 = divide, bit0 = unsigned
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply / restoring divide unit owning the HI/LO registers.
// Signed ops run on magnitudes; the FIX state applies sign correction.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             wr_hi,
    input  logic             wr_lo,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    md_state_e state;
    md_state_e state_nxt;

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;

    logic             load;
    logic             step;
    logic             fix;
    logic             idle_wr;

    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             last_step;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_sub;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    // Operand conditioning at start
    always_comb begin
        op_signed = ~op[0];
        a_neg     = op_signed & a[WIDTH-1];
        b_neg     = op_signed & b[WIDTH-1];
        a_mag     = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag     = b_neg ? (~b + WIDTH'(1)) : b;
        div_zero  = op[1] & (b == '0);
        last_step = (count == CNT_W'(WIDTH - 1));
    end

    // One shift-add / shift-subtract step
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        rem_shift = {acc_hi, acc_lo[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, opnd};
        div_ge    = (rem_shift >= {1'b0, opnd});
        div_rem   = div_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        prod      = {acc_hi, acc_lo};
        prod_neg  = ~prod + (2*WIDTH)'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = div_zero ? FIX : RUN;
                RUN:     if (last_step) state_nxt = FIX;
                FIX:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state != IDLE);
        load    = (state == IDLE) & start & ~flush;
        step    = (state == RUN) & ~flush;
        fix     = (state == FIX) & ~flush;
        idle_wr = (state == IDLE);
    end

    // Iteration datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (load) begin
            count  <= '0;
            is_div <= op[1];
            if (div_zero) begin
                // FIX then writes these through unchanged
                acc_hi  <= a;
                acc_lo  <= '1;
                opnd    <= '0;
                neg_res <= 1'b0;
                neg_rem <= 1'b0;
            end else if (op[1]) begin
                acc_hi  <= '0;
                acc_lo  <= a_mag;
                opnd    <= b_mag;
                neg_res <= a_neg ^ b_neg;
                neg_rem <= a_neg;
            end else begin
                acc_hi  <= '0;
                acc_lo  <= b_mag;
                opnd    <= a_mag;
                neg_res <= a_neg ^ b_neg;
                neg_rem <= 1'b0;
            end
        end else if (step) begin
            count <= count + CNT_W'(1);
            if (is_div) begin
                acc_hi <= div_rem;
                acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
            end else begin
                acc_hi <= mul_sum[WIDTH:1];
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    // Architectural HI/LO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if (fix) begin
            if (is_div) begin
                hi <= neg_rem ? (~acc_hi + WIDTH'(1)) : acc_hi;
                lo <= neg_res ? (~acc_lo + WIDTH'(1)) : acc_lo;
            end else begin
                {hi, lo} <= neg_res ? prod_neg : prod;
            end
        end else if (idle_wr) begin
            if (wr_hi) hi <= a;
            if (wr_lo) lo <= a;
        end
    end

endmodule

// File: rtl/alu_mdu_ctrl.sv
// ALU control decode with an attached iterative MD unit, HI/LO access and pipeline stall.
module alu_mdu_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid,
    input  logic              flush,
    input  logic [2:0]        aluop,
    input  logic [5:0]        funct,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [CTRL_W-1:0] alucontrol,
    output logic              jr,
    output logic              illegal,
    output logic              md_sel,
    output logic [WIDTH-1:0]  md_rdata,
    output logic              busy,
    output logic              stall
);

    logic [ALU_CTRL_W-1:0] ctrl;
    logic                  rtype;
    logic                  qual;
    logic                  md_op;
    logic                  is_mfhi;
    logic                  is_mflo;
    logic                  is_mthi;
    logic                  is_mtlo;
    logic                  start;
    logic                  wr_hi;
    logic                  wr_lo;
    logic [WIDTH-1:0]      hi;
    logic [WIDTH-1:0]      lo;

    // Main ALU operation decode
    always_comb begin
        ctrl    = ALU_ADD;
        illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: ctrl = ALU_ADD;
            ALUOP_SUB: ctrl = ALU_SUB;
            ALUOP_OR:  ctrl = ALU_OR;
            ALUOP_AND: ctrl = ALU_AND;
            ALUOP_XOR: ctrl = ALU_XOR;
            ALUOP_RTYPE: begin
                case (funct)
                    F_ADD:  ctrl = ALU_ADD;
                    F_SUB:  ctrl = ALU_SUB;
                    F_AND:  ctrl = ALU_AND;
                    F_OR:   ctrl = ALU_OR;
                    F_XOR:  ctrl = ALU_XOR;
                    F_NOR:  ctrl = ALU_NOR;
                    F_SLT:  ctrl = ALU_SLT;
                    F_SLTU: ctrl = ALU_SLTU;
                    F_SLL:  ctrl = ALU_SLL;
                    F_SRL:  ctrl = ALU_SRL;
                    F_SRA:  ctrl = ALU_SRA;
                    F_MULT, F_MULTU, F_DIV, F_DIVU,
                    F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                    F_JR:   ctrl = ALU_ADD;
                    default: begin
                        ctrl    = ALU_ILLEGAL;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: ctrl = ALU_ADD;
        endcase
    end

    assign alucontrol = CTRL_W'(ctrl);

    // MD / HI-LO instruction qualification and hazard stall
    always_comb begin
        rtype   = (aluop == ALUOP_RTYPE);
        qual    = valid & rtype;
        jr      = rtype & (funct == F_JR);
        md_op   = qual & (funct[5:2] == F_MULT[5:2]);
        is_mfhi = qual & (funct == F_MFHI);
        is_mflo = qual & (funct == F_MFLO);
        is_mthi = qual & (funct == F_MTHI);
        is_mtlo = qual & (funct == F_MTLO);
        stall   = busy & (md_op | is_mfhi | is_mflo | is_mthi | is_mtlo);
        start   = md_op & ~stall;
        wr_hi   = is_mthi & ~stall;
        wr_lo   = is_mtlo & ~stall;
    end

    always_comb begin
        md_sel   = is_mfhi | is_mflo;
        md_rdata = '0;
        if (is_mfhi) begin
            md_rdata = hi;
        end else if (is_mflo) begin
            md_rdata = lo;
        end
    end

    mdu_iter #(
        .WIDTH (WIDTH)
    ) u_mdu (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (funct[1:0]),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Bench for alu_mdu_ctrl: decode sweep, directed and random MD ops against an arithmetic model.
module tb_alu_mdu_ctrl;

    localparam int unsigned W = 32;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         valid = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   aluop = 3'b000;
    logic [5:0]   funct = 6'b100000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   alucontrol;
    logic         jr;
    logic         illegal;
    logic         md_sel;
    logic [W-1:0] md_rdata;
    logic         busy;
    logic         stall;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    alu_mdu_ctrl #(.WIDTH(W), .CTRL_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid      (valid),
        .flush      (flush),
        .aluop      (aluop),
        .funct      (funct),
        .a          (a),
        .b          (b),
        .alucontrol (alucontrol),
        .jr         (jr),
        .illegal    (illegal),
        .md_sel     (md_sel),
        .md_rdata   (md_rdata),
        .busy       (busy),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    // Expected {illegal, alucontrol} for an R-type funct
    function automatic logic [4:0] exp_rtype(input int f);
        case (f)
            32: return 5'b0_0010;
            34: return 5'b0_0110;
            36: return 5'b0_0000;
            37: return 5'b0_0001;
            38: return 5'b0_0011;
            39: return 5'b0_0100;
            42: return 5'b0_0111;
            43: return 5'b0_0101;
            0:  return 5'b0_1001;
            2:  return 5'b0_1000;
            3:  return 5'b0_1010;
            8, 16, 17, 18, 19, 24, 25, 26, 27: return 5'b0_0010;
            default: return 5'b1_1111;
        endcase
    endfunction

    // Arithmetic reference for the MD ops
    task automatic ref_md(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, q, r;
        longint unsigned ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        if (f[1] && y == '0) begin
            m_hi = x;
            m_lo = '1;
        end else if (f == FN_MULT) begin
            p = longint'(sx * sy);
            {m_hi, m_lo} = p;
        end else if (f == FN_MULTU) begin
            p = ux * uy;
            {m_hi, m_lo} = p;
        end else if (f == FN_DIV) begin
            q = sx / sy;
            r = sx % sy;
            m_lo = q[31:0];
            m_hi = r[31:0];
        end else begin
            p = ux / uy;
            m_lo = p[31:0];
            p = ux % uy;
            m_hi = p[31:0];
        end
    endtask

    task automatic read_hilo(input string tag);
        valid = 1'b1;
        aluop = 3'b010;
        funct = FN_MFHI;
        #1;
        check({tag, " md_sel"}, 64'(md_sel), 64'd1);
        check({tag, " hi"}, 64'(md_rdata), 64'(m_hi));
        funct = FN_MFLO;
        #1;
        check({tag, " lo"}, 64'(md_rdata), 64'(m_lo));
        valid = 1'b0;
        funct = FN_ADD;
    endtask

    task automatic run_md(input string tag, input logic [5:0] f, input logic [W-1:0] x,
                          input logic [W-1:0] y);
        int cycles;
        int exp_cycles;
        valid = 1'b1;
        aluop = 3'b010;
        funct = f;
        a = x;
        b = y;
        go();
        valid = 1'b0;
        funct = FN_ADD;
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            go();
        end
        exp_cycles = (f[1] && y == '0) ? 1 : W + 1;
        check({tag, " busy_cycles"}, 64'(cycles), 64'(exp_cycles));
        ref_md(f, x, y);
        read_hilo(tag);
    endtask

    initial begin
        logic [5:0] fr;
        logic [W-1:0] ra, rb;
        int cyc;

        // Reset state
        #3;
        check("rst busy", 64'(busy), 64'd0);
        check("rst stall", 64'(stall), 64'd0);
        read_hilo("rst");
        go();
        go();
        reset_n = 1'b1;
        go();

        // Decode sweep
        aluop = 3'b010;
        valid = 1'b0;
        for (int f = 0; f < 64; f++) begin
            funct = 6'(f);
            #1;
            check($sformatf("rtype ctrl f=%0d", f), 64'(alucontrol), 64'(exp_rtype(f) & 5'h0f));
            check($sformatf("rtype illegal f=%0d", f), 64'(illegal), 64'(exp_rtype(f) >> 4));
            check($sformatf("rtype jr f=%0d", f), 64'(jr), 64'(f == 8));
        end
        for (int op = 0; op < 8; op++) begin
            logic [3:0] e;
            if (op == 2) continue;
            aluop = 3'(op);
            funct = 6'(op * 7 + 1);
            e = (op == 1) ? 4'b0110 : (op == 3) ? 4'b0001 : (op == 4) ? 4'b0000 :
                (op == 5) ? 4'b0011 : 4'b0010;
            #1;
            check($sformatf("aluop ctrl op=%0d", op), 64'(alucontrol), 64'(e));
            check($sformatf("aluop illegal op=%0d", op), 64'(illegal), 64'd0);
        end
        aluop = 3'b010;
        funct = FN_ADD;
        go();

        // Directed MD ops
        run_md("mult -7*6", FN_MULT, 32'hFFFFFFF9, 32'd6);
        check("mult hi const", 64'(m_hi), 64'hFFFFFFFF);
        run_md("multu", FN_MULTU, 32'hFFFFFFF9, 32'd6);
        run_md("div -17/5", FN_DIV, 32'hFFFFFFEF, 32'd5);
        run_md("divu 100/7", FN_DIVU, 32'd100, 32'd7);
        run_md("divu by 0", FN_DIVU, 32'h1234, 32'd0);
        run_md("div by 0", FN_DIV, 32'h8000_0001, 32'd0);
        run_md("div minint/-1", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

        // Random MD ops
        for (int i = 0; i < 16; i++) begin
            fr = {4'b0110, 2'($urandom_range(0, 3))};
            ra = $urandom;
            rb = (i % 5 == 4) ? '0 : ((i % 2 == 0) ? W'($urandom_range(1, 1000)) : W'($urandom));
            run_md($sformatf("rand%0d f=%0d", i, fr), fr, ra, rb);
        end

        // mflo issued mid-operation stalls until busy falls
        ra = $urandom;
        rb = $urandom;
        valid = 1'b1;
        funct = FN_MULT;
        a = ra;
        b = rb;
        go();
        valid = 1'b0;
        funct = FN_ADD;
        repeat (4) go();
        valid = 1'b1;
        funct = FN_MFLO;
        #1;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            check("mflo stall", 64'(stall), 64'd1);
            cyc++;
            go();
        end
        check("mflo stall cycles", 64'(cyc), 64'(W + 1 - 4));
        ref_md(FN_MULT, ra, rb);
        check("mflo after stall", 64'(stall), 64'd0);
        check("mflo md_sel", 64'(md_sel), 64'd1);
        check("mflo data", 64'(md_rdata), 64'(m_lo));
        valid = 1'b0;
        funct = FN_ADD;

        // Back-to-back: op issued in FIX cycle is held one cycle
        a = 32'd5000;
        b = 32'd3;
        valid = 1'b1;
        funct = FN_MULTU;
        go();
        valid = 1'b0;
        repeat (W) go();
        check("b2b in fix busy", 64'(busy), 64'd1);
        ra = $urandom;
        rb = W'($urandom_range(1, 99));
        a = ra;
        b = rb;
        valid = 1'b1;
        funct = FN_DIVU;
        #1;
        check("b2b fix stall", 64'(stall), 64'd1);
        go();
        check("b2b idle busy", 64'(busy), 64'd0);
        check("b2b idle stall", 64'(stall), 64'd0);
        go();
        check("b2b started", 64'(busy), 64'd1);
        valid = 1'b0;
        funct = FN_ADD;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            go();
        end
        check("b2b cycles", 64'(cyc), 64'(W + 1));
        ref_md(FN_DIVU, ra, rb);
        read_hilo("b2b");

        // Flush beats a same-cycle start
        valid = 1'b1;
        funct = FN_MULT;
        a = 32'd9;
        b = 32'd9;
        flush = 1'b1;
        go();
        check("flush vs start busy", 64'(busy), 64'd0);
        flush = 1'b0;
        valid = 1'b0;
        read_hilo("flush vs start");

        // mthi, then flush in RUN cycle 10 leaves HI intact
        valid = 1'b1;
        funct = FN_MTHI;
        a = 32'hAAAA5555;
        go();
        m_hi = 32'hAAAA5555;
        a = 32'h0BADF00D;
        funct = FN_MTLO;
        go();
        m_lo = 32'h0BADF00D;
        funct = FN_MULT;
        a = 32'd123;
        b = 32'd456;
        go();
        valid = 1'b0;
        funct = FN_ADD;
        repeat (9) go();
        check("pre flush busy", 64'(busy), 64'd1);
        flush = 1'b1;
        go();
        check("post flush busy", 64'(busy), 64'd0);
        flush = 1'b0;
        read_hilo("flush");

        // Asynchronous reset mid-divide
        valid = 1'b1;
        funct = FN_DIV;
        a = $urandom;
        b = 32'd7;
        go();
        valid = 1'b0;
        funct = FN_ADD;
        repeat (5) go();
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst busy", 64'(busy), 64'd0);
        m_hi = '0;
        m_lo = '0;
        valid = 1'b1;
        aluop = 3'b010;
        funct = FN_MFHI;
        #1;
        check("async rst stall", 64'(stall), 64'd0);
        read_hilo("async rst");
        go();
        reset_n = 1'b1;
        go();
        run_md("mult 3*4", FN_MULT, 32'd3, 32'd4);
        check("mult 3*4 lo const", 64'(m_lo), 64'd12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
